sap_datapath: RTL and testbench
===============================

Name: sap_datapath

Overview:
- Execution end of the CPU control-word interface: consumes the 15-bit control word from the control sequencer and performs the register transfers it commands.
- Contains PC, MAR, MDR, 16-entry RAM, IR, accumulator A, register B, add/sub unit, output register and the shared 8-bit bus.
- Returns the current opcode (IR[7:4]) to the sequencer.
- Includes a program-load port so RAM can be filled before run.

Parameters:
- DATA_W, 8, bus, register and RAM word width (only 8 is supported).
- ADDR_W, 4, PC/MAR width; RAM depth is 2**ADDR_W.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ctrl  in  15  control word; bit map below.
- prog_mode  in  1  1 = program-load mode; ctrl is treated as fully deasserted.
- prog_we  in  1  RAM write strobe (only used when prog_mode=1).
- prog_addr  in  ADDR_W  RAM write address in program-load mode.
- prog_data  in  DATA_W  RAM write data in program-load mode.
- opcode  out  4  IR[7:4] to the sequencer.
- out_data  out  DATA_W  output register contents.
- out_valid  out  1  one-cycle pulse after each output-register load.
- bus_dbg  out  DATA_W  current bus value.
- pc_dbg  out  ADDR_W  current PC.
- carry  out  1  carry/borrow out of the add/sub unit (combinational).
- zero  out  1  1 when the add/sub result is 0 (combinational).
- bus_conflict  out  1  sticky error flag; more than one bus driver was enabled.

Behaviour:
- Control bit map (n = active-low):
  - 14 PC_INC, 13 PC_EN, 12 PC_LOAD
  - 11 MAR_ADDR_LOAD_n, 10 MAR_MEM_LOAD_n, 9 RAM_EN_n, 8 RAM_LOAD_n
  - 7 IR_LOAD_n, 6 IR_EN_n, 5 A_LOAD_n, 4 A_EN
  - 3 SUB, 2 ALU_EN, 1 B_LOAD_n, 0 OUT_LOAD_n
- Idle (all deasserted) word is 15'b000111111100011. The sequencer changes ctrl on the falling clock edge; this block samples ctrl on the rising edge.
- Reset (rst_n=0 at posedge): PC=PC_RESET; MAR, MDR, IR, A, B, OUT = 0; out_valid=0; bus_conflict=0. RAM contents are not reset.
- Bus is combinational from current ctrl and register state. Drivers:
  - PC_EN: {0, PC}
  - RAM_EN_n=0: RAM[MAR]
  - IR_EN_n=0: {0, IR[3:0]}
  - A_EN: A
  - ALU_EN: ALU result
- Bus contention:
  - No driver enabled: bus = 0.
  - Two or more enabled: bus = bitwise OR of the enabled sources, and bus_conflict sets at the next posedge and holds until reset.
- ALU:
  - result = (A + B) mod 256 when SUB=0; (A + ~B + 1) mod 256 when SUB=1.
  - carry = bit 8 of that sum; zero = (result == 0).
- Posedge register updates (all take the pre-edge bus value):
  - MAR_ADDR_LOAD_n=0: MAR <= bus[3:0].
  - MAR_MEM_LOAD_n=0: MDR <= bus.
  - RAM_LOAD_n=0: RAM[MAR] <= MDR, using the pre-edge MDR. If MDR is loaded in the same cycle, the old MDR is written.
  - IR_LOAD_n=0: IR <= bus.
  - A_LOAD_n=0: A <= bus. A_EN and A_LOAD_n together legal only via ALU path; A reloads its own value, conflict rules apply.
  - B_LOAD_n=0: B <= bus.
  - OUT_LOAD_n=0: OUT <= bus; out_valid=1 in the following cycle only.
- PC:
  - PC_LOAD: PC <= bus[3:0]; PC_LOAD has priority over PC_INC.
  - PC_INC: PC <= PC+1, wrapping 15 to 0.
- prog_mode=1:
  - ctrl is ignored; no datapath register changes.
  - prog_we=1: RAM[prog_addr] <= prog_data.
  - out_valid=0.
- prog_mode=0: prog_we is ignored.
- Reset asserted mid-instruction: registers clear at that edge; any RAM write enabled in that cycle is suppressed.
- opcode = IR[7:4], combinational from IR.

Test Plan:
- Reset → PC=0, A=B=OUT=IR=0, opcode=0, out_valid=0, bus_conflict=0, bus_dbg=0 with idle ctrl.
- Program RAM[0]=0x49, [1]=0x2A, [2]=0x50, [3]=0x00, [9]=0x05, [10]=0x03; run sequencer-timed words for LDA 9, ADD A, OUT → A=0x08, out_data=0x08 with a single out_valid pulse, PC=3, opcode=0 after the fourth fetch.
- SUB with A=0x03, B=0x05 → ALU result 0xFE, carry=0, zero=0; with A=B=0x05 → result 0x00, zero=1, carry=1.
- STA: A=0x77, MAR=0xC, MDR loaded from A, then RAM_LOAD_n → RAM[12]=0x77 on readback via RAM_EN_n.
- PC: PC=15 with PC_INC → PC=0; PC_INC and PC_LOAD together with IR[3:0]=0x6 on bus → PC=6.
- Conflict: PC_EN and A_EN both asserted, PC=0x2, A=0x50 → bus_dbg=0x52, bus_conflict=1 and held through idle cycles until rst_n=0.

Source files
------------

// File: rtl/sap_datapath_if.sv
// sap_datapath_if: control word, program-load port and status outputs of the SAP datapath
interface sap_datapath_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [14:0]       i_ctrl;
   logic              i_prog_mode;
   logic              i_prog_we;
   logic [ADDR_W-1:0] i_prog_addr;
   logic [DATA_W-1:0] i_prog_data;
   logic [3:0]        o_opcode;
   logic [DATA_W-1:0] o_out_data;
   logic              o_out_valid;
   logic [DATA_W-1:0] o_bus_dbg;
   logic [ADDR_W-1:0] o_pc_dbg;
   logic              o_carry;
   logic              o_zero;
   logic              o_bus_conflict;
   modport slave (
      input  i_ctrl, i_prog_mode, i_prog_we, i_prog_addr, i_prog_data,
      output o_opcode, o_out_data, o_out_valid, o_bus_dbg, o_pc_dbg, o_carry, o_zero, o_bus_conflict
   );
   modport master (
      output i_ctrl, i_prog_mode, i_prog_we, i_prog_addr, i_prog_data,
      input  o_opcode, o_out_data, o_out_valid, o_bus_dbg, o_pc_dbg, o_carry, o_zero, o_bus_conflict
   );
endinterface

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 execution datapath performing the register transfers of a 15-bit control word
module sap_datapath #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 4,
   parameter int PC_RESET = 0
) (
   input logic          clk,
   input logic          rst_n,
   sap_datapath_if.slave io
);
   localparam logic [14:0] IDLE = 15'b000111111100011;
   logic [14:0]       w_c;
   logic              w_pc_inc, w_pc_en, w_pc_load, w_mar_ld, w_mdr_ld, w_ram_en, w_ram_ld;
   logic              w_ir_ld, w_ir_en, w_a_ld, w_a_en, w_sub, w_alu_en, w_b_ld, w_out_ld;
   logic [ADDR_W-1:0] r_pc, r_mar;
   logic [DATA_W-1:0] r_mdr, r_ir, r_a, r_b, r_out, w_bus;
   logic [DATA_W:0]   w_sum;
   logic              r_out_valid, r_conflict, w_conflict;
   logic [DATA_W-1:0] r_ram [2**ADDR_W];
   // program-load mode looks to the datapath exactly like an idle control word
   assign w_c = io.i_prog_mode ? IDLE : io.i_ctrl;
   assign {w_pc_inc, w_pc_en, w_pc_load} = w_c[14:12];
   assign w_mar_ld = ~w_c[11];
   assign w_mdr_ld = ~w_c[10];
   assign w_ram_en = ~w_c[9];
   assign w_ram_ld = ~w_c[8];
   assign w_ir_ld  = ~w_c[7];
   assign w_ir_en  = ~w_c[6];
   assign w_a_ld   = ~w_c[5];
   assign {w_a_en, w_sub, w_alu_en} = w_c[4:2];
   assign w_b_ld   = ~w_c[1];
   assign w_out_ld = ~w_c[0];
   assign w_sum = {1'b0, r_a} + {1'b0, w_sub ? ~r_b : r_b} + {{DATA_W{1'b0}}, w_sub};
   assign w_bus = (w_pc_en  ? DATA_W'(r_pc)        : '0)
                | (w_ram_en ? r_ram[r_mar]         : '0)
                | (w_ir_en  ? DATA_W'(r_ir[3:0])   : '0)
                | (w_a_en   ? r_a                  : '0)
                | (w_alu_en ? w_sum[DATA_W-1:0]    : '0);
   assign w_conflict = !$onehot0({w_pc_en, w_ram_en, w_ir_en, w_a_en, w_alu_en});
   always_ff @(posedge clk)
      if (rst_n && (io.i_prog_mode ? io.i_prog_we : w_ram_ld))
         r_ram[io.i_prog_mode ? io.i_prog_addr : r_mar] <= io.i_prog_mode ? io.i_prog_data : r_mdr;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc        <= ADDR_W'(PC_RESET);
         r_mar       <= '0;
         r_mdr       <= '0;
         r_ir        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_conflict  <= 1'b0;
      end else begin
         if (w_mar_ld) r_mar <= w_bus[ADDR_W-1:0];
         if (w_mdr_ld) r_mdr <= w_bus;
         if (w_ir_ld)  r_ir  <= w_bus;
         if (w_a_ld)   r_a   <= w_bus;
         if (w_b_ld)   r_b   <= w_bus;
         if (w_out_ld) r_out <= w_bus;
         if (w_pc_load)     r_pc <= w_bus[ADDR_W-1:0];
         else if (w_pc_inc) r_pc <= r_pc + 1'b1;
         r_out_valid <= w_out_ld;
         r_conflict  <= r_conflict | w_conflict;
      end
   end
   assign io.o_opcode       = r_ir[DATA_W-1:DATA_W-4];
   assign io.o_out_data     = r_out;
   assign io.o_out_valid    = r_out_valid;
   assign io.o_bus_dbg      = w_bus;
   assign io.o_pc_dbg       = r_pc;
   assign io.o_carry        = w_sum[DATA_W];
   assign io.o_zero         = (w_sum[DATA_W-1:0] == '0);
   assign io.o_bus_conflict = r_conflict;
endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed SAP program plus randomized control words against a transfer-level model
module tb_sap_datapath;
   localparam logic [14:0] IDLE = 15'b000111111100011;
   localparam logic [14:0] PCI = 15'h4000, PCE = 15'h2000, PCL = 15'h1000, MARA = 15'h0800;
   localparam logic [14:0] MDRL = 15'h0400, RAME = 15'h0200, RAML = 15'h0100, IRL = 15'h0080;
   localparam logic [14:0] IRE = 15'h0040, AL = 15'h0020, AEN = 15'h0010, SUB = 15'h0008;
   localparam logic [14:0] ALUE = 15'h0004, BL = 15'h0002, OUTL = 15'h0001;
   localparam logic [14:0] LOADS = PCI | PCL | MARA | MDRL | RAML | IRL | AL | SUB | BL | OUTL;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_err = 0;
   int n_chk = 0;
   int m_pc, m_mar, m_mdr, m_ir, m_a, m_b, m_out;
   bit m_ov, m_conf;
   int m_ram [16];
   logic [14:0] d_eff;
   bit d_pm, d_we, d_rn;
   int d_pa, d_pd;
   sap_datapath_if #(.DATA_W(8), .ADDR_W(4)) u_if ();
   sap_datapath #(.DATA_W(8), .ADDR_W(4), .PC_RESET(0)) dut (.clk(clk), .rst_n(rst_n), .io(u_if));
   always #5 clk = ~clk;
   function automatic logic [14:0] cw(input logic [14:0] asserted);
      return IDLE ^ asserted;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask
   function automatic void mcomb(input logic [14:0] c, output int b, output bit conf, output int alu, output bit cy);
      logic [14:0] act;
      int n;
      act = c ^ IDLE;
      alu = ((act & SUB) != 0) ? (m_a - m_b) & 255 : (m_a + m_b) & 255;
      cy = ((act & SUB) != 0) ? (m_a >= m_b) : (m_a + m_b > 255);
      b = 0;
      n = 0;
      if ((act & PCE) != 0) begin b |= m_pc; n++; end
      if ((act & RAME) != 0) begin b |= m_ram[m_mar]; n++; end
      if ((act & IRE) != 0) begin b |= m_ir % 16; n++; end
      if ((act & AEN) != 0) begin b |= m_a; n++; end
      if ((act & ALUE) != 0) begin b |= alu; n++; end
      conf = n > 1;
   endfunction
   task automatic drive(input logic [14:0] c, input bit pm, input bit we, input int pa, input int pd, input bit rn);
      int b, alu;
      bit cf, cy;
      @(negedge clk);
      u_if.i_ctrl = c;
      u_if.i_prog_mode = pm;
      u_if.i_prog_we = we;
      u_if.i_prog_addr = 4'(pa);
      u_if.i_prog_data = 8'(pd);
      rst_n = rn;
      d_pm = pm; d_we = we; d_pa = pa; d_pd = pd; d_rn = rn;
      d_eff = pm ? IDLE : c;
      #1;
      mcomb(d_eff, b, cf, alu, cy);
      chk("bus", u_if.o_bus_dbg, b);
      chk("carry", u_if.o_carry, cy);
      chk("zero", u_if.o_zero, alu == 0);
   endtask
   task automatic tick();
      int b, alu;
      bit cf, cy;
      logic [14:0] act;
      @(posedge clk);
      act = d_eff ^ IDLE;
      mcomb(d_eff, b, cf, alu, cy);
      if (!d_rn) begin
         m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
         m_ov = 0; m_conf = 0;
      end else if (d_pm) begin
         if (d_we) m_ram[d_pa] = d_pd;
         m_ov = 0;
      end else begin
         if ((act & RAML) != 0) m_ram[m_mar] = m_mdr;
         if ((act & MARA) != 0) m_mar = b % 16;
         if ((act & MDRL) != 0) m_mdr = b;
         if ((act & IRL) != 0) m_ir = b;
         if ((act & AL) != 0) m_a = b;
         if ((act & BL) != 0) m_b = b;
         if ((act & OUTL) != 0) m_out = b;
         m_ov = (act & OUTL) != 0;
         if ((act & PCL) != 0) m_pc = b % 16;
         else if ((act & PCI) != 0) m_pc = (m_pc + 1) % 16;
         m_conf |= cf;
      end
      #1;
      chk("pc", u_if.o_pc_dbg, m_pc);
      chk("out_data", u_if.o_out_data, m_out);
      chk("out_valid", u_if.o_out_valid, m_ov);
      chk("opcode", u_if.o_opcode, m_ir / 16);
      chk("bus_conflict", u_if.o_bus_conflict, m_conf);
   endtask
   task automatic step(input logic [14:0] c);
      drive(c, 0, 0, 0, 0, 1);
      tick();
   endtask
   task automatic prog(input int a, input int d);
      drive(IDLE, 1, 1, a, d, 1);
      tick();
   endtask
   task automatic put(input logic [14:0] ld, input int d);
      prog(m_mar, d);
      step(cw(RAME | ld));
   endtask
   task automatic fetch();
      step(cw(PCE | MARA));
      step(cw(RAME | IRL | PCI));
   endtask
   initial begin
      logic [14:0] drv [6];
      drv = '{15'h0, PCE, RAME, IRE, AEN, ALUE};
      u_if.i_ctrl = IDLE;
      u_if.i_prog_mode = 1'b0;
      u_if.i_prog_we = 1'b0;
      u_if.i_prog_addr = '0;
      u_if.i_prog_data = '0;
      repeat (2) @(posedge clk);
      m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0;
      m_ov = 0; m_conf = 0;
      for (int i = 0; i < 16; i++) m_ram[i] = 0;
      drive(IDLE, 0, 0, 0, 0, 0);
      chk("rst_bus_idle", u_if.o_bus_dbg, 0);
      tick();
      chk("rst_pc", u_if.o_pc_dbg, 0);
      chk("rst_opcode", u_if.o_opcode, 0);
      chk("rst_out", u_if.o_out_data, 0);
      chk("rst_valid", u_if.o_out_valid, 0);
      chk("rst_conflict", u_if.o_bus_conflict, 0);
      for (int i = 0; i < 16; i++) prog(i, $urandom_range(0, 255));
      prog(0, 8'h49); prog(1, 8'h2A); prog(2, 8'h50); prog(3, 8'h00);
      prog(9, 8'h05); prog(10, 8'h03);
      chk("prog_pc_held", u_if.o_pc_dbg, 0);
      fetch();
      chk("lda_opcode", u_if.o_opcode, 4);
      step(cw(IRE | MARA));
      step(cw(RAME | AL));
      fetch();
      chk("add_opcode", u_if.o_opcode, 2);
      step(cw(IRE | MARA));
      step(cw(RAME | BL));
      step(cw(ALUE | AL));
      fetch();
      chk("out_opcode", u_if.o_opcode, 5);
      drive(cw(AEN | OUTL), 0, 0, 0, 0, 1);
      chk("a_on_bus", u_if.o_bus_dbg, 8'h08);
      tick();
      chk("out_result", u_if.o_out_data, 8'h08);
      chk("out_pulse", u_if.o_out_valid, 1);
      step(IDLE);
      chk("out_pulse_end", u_if.o_out_valid, 0);
      chk("pc_after_out", u_if.o_pc_dbg, 3);
      fetch();
      chk("hlt_opcode", u_if.o_opcode, 0);
      put(AL, 8'h03);
      put(BL, 8'h05);
      drive(cw(ALUE | SUB), 0, 0, 0, 0, 1);
      chk("sub_res", u_if.o_bus_dbg, 8'hFE);
      chk("sub_carry", u_if.o_carry, 0);
      chk("sub_zero", u_if.o_zero, 0);
      tick();
      put(AL, 8'h05);
      drive(cw(ALUE | SUB), 0, 0, 0, 0, 1);
      chk("subz_res", u_if.o_bus_dbg, 8'h00);
      chk("subz_carry", u_if.o_carry, 1);
      chk("subz_zero", u_if.o_zero, 1);
      tick();
      put(AL, 8'h77);
      put(MARA, 8'h0C);
      step(cw(AEN | MDRL));
      step(cw(RAML));
      drive(cw(RAME), 0, 0, 0, 0, 1);
      chk("sta_readback", u_if.o_bus_dbg, 8'h77);
      tick();
      put(PCL, 15);
      chk("pc_15", u_if.o_pc_dbg, 15);
      step(cw(PCI));
      chk("pc_wrap", u_if.o_pc_dbg, 0);
      put(IRL, 8'h06);
      step(cw(IRE | PCI | PCL));
      chk("pc_load_prio", u_if.o_pc_dbg, 6);
      put(PCL, 2);
      put(AL, 8'h50);
      drive(cw(PCE | AEN), 0, 0, 0, 0, 1);
      chk("conflict_bus", u_if.o_bus_dbg, 8'h52);
      tick();
      chk("conflict_set", u_if.o_bus_conflict, 1);
      repeat (3) step(IDLE);
      chk("conflict_held", u_if.o_bus_conflict, 1);
      drive(cw(RAML), 0, 0, 0, 0, 0);
      tick();
      chk("conflict_clear", u_if.o_bus_conflict, 0);
      step(cw(RAME));
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r < 3) prog($urandom_range(0, 15), $urandom_range(0, 255));
         else if (r == 3) begin
            drive(15'($urandom), 0, 0, 0, 0, 0);
            tick();
         end else if (r == 4) begin
            drive(15'($urandom), 0, 1, $urandom_range(0, 15), $urandom_range(0, 255), 1);
            tick();
         end else step(cw(drv[$urandom_range(0, 5)] | (15'($urandom) & LOADS)));
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
